hs32_decode2_pipe: RTL and testbench

Parametrised, registered successor to the second decode stage. It reads the Rm operand from the register file, selects the Rn operand from N forwarding sources, and applies shift or rotate to it. It also checks Rm against a configurable hazard scoreboard and generates ALU controls. Results are held in an output pipeline register with a valid/ready handshake, flush, and a saturating hazard-stall counter; the stage sits between decode1 and execute.

---
 rtl/hs32_decode2_pipe_if.sv | 67 ++++++
 rtl/hs32_decode2_pipe.sv | 165 ++++++++++++++++
 tb/tb_hs32_decode2_pipe.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs32_decode2_pipe_if.sv
// Signal bundle for the second decode stage: decode1 packet in, regfile/forward/scoreboard taps,
// registered packet out to execute, and the stall counter.
interface hs32_decode2_pipe_if #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN),
   parameter int NFWD = 2,
   parameter int NHZ  = 3,
   parameter int CNTW = 16
);
   localparam int FSW = $clog2(NFWD + 1);

   logic                 flush_i;
   logic                 in_vld;
   logic                 in_rdy;
   logic [4:0]           in_opc;
   logic [3:0]           in_rd;
   logic [3:0]           in_rm;
   logic [XLEN-1:0]      in_d2;
   logic [FSW-1:0]       in_fsel;
   logic [SHW-1:0]       in_shl;
   logic [SHW-1:0]       in_shr;
   logic                 in_maskl;
   logic                 in_maskr;
   logic                 in_sext;
   logic                 in_ror;
   logic [3:0]           rp_addr;
   logic [XLEN-1:0]      rp_data;
   logic [XLEN*NFWD-1:0] fwd_data;
   logic [NHZ-1:0]       haz_vld;
   logic [4*NHZ-1:0]     haz_rd;
   logic [NHZ-1:0]       haz_fwdok;
   logic                 out_vld;
   logic                 out_rdy;
   logic [XLEN-1:0]      out_d1;
   logic [XLEN-1:0]      out_d2;
   logic [3:0]           out_rd;
   logic                 out_we1;
   logic                 out_isldr;
   logic                 out_isstr;
   logic                 out_neg;
   logic                 out_sub;
   logic                 out_cen;
   logic                 out_fwe;
   logic [1:0]           out_opr;
   logic [NHZ-1:0]       out_fwd;
   logic                 out_s2fwdok;
   logic [CNTW-1:0]      stall_cnt;
   logic                 cnt_clr;

   modport slave (
      input  flush_i, in_vld, in_opc, in_rd, in_rm, in_d2, in_fsel, in_shl, in_shr,
             in_maskl, in_maskr, in_sext, in_ror, rp_data, fwd_data,
             haz_vld, haz_rd, haz_fwdok, out_rdy, cnt_clr,
      output in_rdy, rp_addr, out_vld, out_d1, out_d2, out_rd, out_we1, out_isldr,
             out_isstr, out_neg, out_sub, out_cen, out_fwe, out_opr, out_fwd,
             out_s2fwdok, stall_cnt
   );

   modport master (
      output flush_i, in_vld, in_opc, in_rd, in_rm, in_d2, in_fsel, in_shl, in_shr,
             in_maskl, in_maskr, in_sext, in_ror, rp_data, fwd_data,
             haz_vld, haz_rd, haz_fwdok, out_rdy, cnt_clr,
      input  in_rdy, rp_addr, out_vld, out_d1, out_d2, out_rd, out_we1, out_isldr,
             out_isstr, out_neg, out_sub, out_cen, out_fwe, out_opr, out_fwd,
             out_s2fwdok, stall_cnt
   );
endinterface

// File: rtl/hs32_decode2_pipe.sv
// Second decode stage: Rm read, Rn forward select + shift/rotate, Rm hazard scoreboard check,
// ALU control decode, and a valid/ready output register with flush and a saturating stall counter.
module hs32_decode2_pipe #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN),
   parameter int NFWD = 2,
   parameter int NHZ  = 3,
   parameter int CNTW = 16
) (
   input  logic               clk,
   input  logic               nrst,
   hs32_decode2_pipe_if.slave bus
);
   localparam int FSW = $clog2(NFWD + 1);

   logic                   w_isalu, w_issub, w_iscen, w_isbic, w_ismov;
   logic                   w_isldr, w_isstr, w_islsu;
   logic [1:0]             w_opr;
   logic [XLEN-1:0]        w_src [NFWD+1];
   logic [XLEN-1:0]        w_d2src;
   logic [2*XLEN-1:0]      w_rot2;
   logic [XLEN-1:0]        w_lsr;
   logic signed [XLEN-1:0] w_asr;
   logic [XLEN-1:0]        w_shr;
   logic [XLEN-1:0]        w_shl;
   logic [XLEN-1:0]        w_d2;
   logic [XLEN-1:0]        w_d1;
   logic                   w_s2fwdok;
   logic [NHZ-1:0]         w_match, w_block, w_hit, w_fwd;
   logic                   w_hazard;
   logic                   w_in_rdy;
   logic                   w_load;

   logic                   r_out_vld;
   logic [XLEN-1:0]        r_out_d1, r_out_d2;
   logic [3:0]             r_out_rd;
   logic                   r_out_we1, r_out_isldr, r_out_isstr;
   logic                   r_out_neg, r_out_sub, r_out_cen, r_out_fwe;
   logic [1:0]             r_out_opr;
   logic [NHZ-1:0]         r_out_fwd;
   logic                   r_out_s2fwdok;
   logic [CNTW-1:0]        r_stall_cnt;

   always_comb begin
      w_isalu = bus.in_opc[4];
      w_issub = w_isalu & ~bus.in_opc[2] & bus.in_opc[1];
      w_iscen = w_isalu & ~bus.in_opc[2] & bus.in_opc[0];
      w_isbic = w_isalu & (bus.in_opc[2:0] == 3'b101);
      w_ismov = (bus.in_opc[4:2] == 3'b000);
      w_isldr = (bus.in_opc == 5'b01000);
      w_isstr = (bus.in_opc == 5'b01001);
      w_islsu = w_isldr | w_isstr;
      if (w_ismov || w_islsu)   w_opr = 2'd0;
      else if (!bus.in_opc[2])  w_opr = 2'd0;
      else if (!bus.in_opc[1])  w_opr = 2'd1;
      else if (!bus.in_opc[0])  w_opr = 2'd2;
      else                      w_opr = 2'd3;
   end

   // Source 0 is the decode1 operand, source k is forwarding slice k-1.
   assign w_src[0] = bus.in_d2;
   generate
      for (genvar gi = 0; gi < NFWD; gi++) begin : g_fwd_src
         assign w_src[gi+1] = bus.fwd_data[gi*XLEN +: XLEN];
      end
   endgenerate

   always_comb begin
      w_d2src = '0;
      for (int k = 0; k <= NFWD; k++) begin
         if (bus.in_fsel == FSW'(k)) w_d2src = w_src[k];
      end
   end

   assign w_rot2 = {w_d2src, w_d2src} >> bus.in_shr;
   assign w_lsr  = w_d2src >> bus.in_shr;
   assign w_asr  = $signed(w_d2src) >>> bus.in_shr;
   assign w_shr  = bus.in_sext ? w_asr : w_lsr;
   assign w_shl  = w_d2src << bus.in_shl;
   assign w_d2   = bus.in_ror ? w_rot2[XLEN-1:0]
                              : ((w_shr & {XLEN{bus.in_maskr}}) | (w_shl & {XLEN{bus.in_maskl}}));
   assign w_d1   = w_ismov ? '0 : bus.rp_data;
   assign w_s2fwdok = !w_islsu && (bus.in_shl == SHW'(0)) && (bus.in_shr == SHW'(0)) && !bus.in_ror;

   generate
      for (genvar gi = 0; gi < NHZ; gi++) begin : g_haz
         assign w_match[gi] = bus.haz_vld[gi] && (bus.haz_rd[gi*4 +: 4] == bus.in_rm);
      end
   endgenerate

   assign w_block  = w_match & ~bus.haz_fwdok;
   assign w_hit    = w_match & bus.haz_fwdok;
   assign w_hazard = |w_block;
   // Isolating the lowest set bit gives priority to the nearest downstream stage.
   assign w_fwd    = w_hit & (~w_hit + NHZ'(1));

   assign w_in_rdy = (!r_out_vld || bus.out_rdy) && !w_hazard && !bus.flush_i;
   assign w_load   = bus.in_vld && w_in_rdy;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_out_vld     <= 1'b0;
         r_out_d1      <= '0;
         r_out_d2      <= '0;
         r_out_rd      <= '0;
         r_out_we1     <= 1'b0;
         r_out_isldr   <= 1'b0;
         r_out_isstr   <= 1'b0;
         r_out_neg     <= 1'b0;
         r_out_sub     <= 1'b0;
         r_out_cen     <= 1'b0;
         r_out_fwe     <= 1'b0;
         r_out_opr     <= '0;
         r_out_fwd     <= '0;
         r_out_s2fwdok <= 1'b0;
      end else if (bus.flush_i) begin
         r_out_vld <= 1'b0;
      end else if (w_load) begin
         r_out_vld     <= 1'b1;
         r_out_d1      <= w_d1;
         r_out_d2      <= w_d2;
         r_out_rd      <= bus.in_rd;
         r_out_we1     <= !w_islsu;
         r_out_isldr   <= w_isldr;
         r_out_isstr   <= w_isstr;
         r_out_neg     <= w_isbic | w_issub;
         r_out_sub     <= w_issub;
         r_out_cen     <= w_iscen;
         r_out_fwe     <= bus.in_opc[4];
         r_out_opr     <= w_opr;
         r_out_fwd     <= w_fwd;
         r_out_s2fwdok <= w_s2fwdok;
      end else if (bus.out_rdy) begin
         r_out_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_stall_cnt <= '0;
      end else if (bus.cnt_clr) begin
         r_stall_cnt <= '0;
      end else if (bus.in_vld && w_hazard && !bus.flush_i && !(&r_stall_cnt)) begin
         r_stall_cnt <= r_stall_cnt + CNTW'(1);
      end
   end

   assign bus.in_rdy      = w_in_rdy;
   assign bus.rp_addr     = bus.in_rm;
   assign bus.out_vld     = r_out_vld;
   assign bus.out_d1      = r_out_d1;
   assign bus.out_d2      = r_out_d2;
   assign bus.out_rd      = r_out_rd;
   assign bus.out_we1     = r_out_we1;
   assign bus.out_isldr   = r_out_isldr;
   assign bus.out_isstr   = r_out_isstr;
   assign bus.out_neg     = r_out_neg;
   assign bus.out_sub     = r_out_sub;
   assign bus.out_cen     = r_out_cen;
   assign bus.out_fwe     = r_out_fwe;
   assign bus.out_opr     = r_out_opr;
   assign bus.out_fwd     = r_out_fwd;
   assign bus.out_s2fwdok = r_out_s2fwdok;
   assign bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_hs32_decode2_pipe.sv
// Bench for hs32_decode2_pipe: directed vector table, hand-written handshake/hazard/flush/reset
// sequences, a CNTW=2 saturation instance, and randomized traffic against a bit-level reference model.
module tb_hs32_decode2_pipe;
   typedef struct {
      logic [4:0]  opc;
      logic [3:0]  rd;
      logic [3:0]  rm;
      logic [31:0] rp;
      logic [31:0] d2;
      logic [1:0]  fsel;
      logic [4:0]  shl;
      logic [4:0]  shr;
      logic        maskl, maskr, sext, ror;
   } pkt_t;

   typedef struct {
      logic [31:0] d1;
      logic [31:0] d2;
      logic [3:0]  rd;
      logic [1:0]  opr;
      logic        neg, sub, cen, fwe, we1, ldr, str, s2;
      logic [2:0]  fwd;
   } res_t;

   typedef struct {
      pkt_t p;
      res_t e;
   } vec_t;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   hs32_decode2_pipe_if #(.XLEN(32), .NFWD(2), .NHZ(3), .CNTW(16)) bus ();
   hs32_decode2_pipe_if #(.XLEN(32), .NFWD(2), .NHZ(3), .CNTW(2))  bus_s ();

   hs32_decode2_pipe #(.XLEN(32), .NFWD(2), .NHZ(3), .CNTW(16)) u_dut (
      .clk(clk), .nrst(nrst), .bus(bus));
   hs32_decode2_pipe #(.XLEN(32), .NFWD(2), .NHZ(3), .CNTW(2)) u_sat (
      .clk(clk), .nrst(nrst), .bus(bus_s));

   int n_cmp = 0;
   int n_err = 0;
   logic [31:0] fwd_v [2];
   vec_t tv [16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic pkt_t mkp(logic [4:0] opc, logic [3:0] rm, logic [31:0] rp, logic [31:0] d2,
                                logic [1:0] fsel, logic [4:0] shl, logic [4:0] shr,
                                logic ml, logic mr, logic sx, logic ro);
      pkt_t p;
      p.opc = opc; p.rd = 4'd0; p.rm = rm; p.rp = rp; p.d2 = d2; p.fsel = fsel;
      p.shl = shl; p.shr = shr; p.maskl = ml; p.maskr = mr; p.sext = sx; p.ror = ro;
      return p;
   endfunction

   function automatic res_t mke(logic [31:0] d1, logic [31:0] d2, logic [1:0] opr, logic neg,
                                logic sub, logic cen, logic fwe, logic we1, logic ldr,
                                logic str, logic s2);
      res_t r;
      r.d1 = d1; r.d2 = d2; r.rd = 4'd0; r.opr = opr; r.neg = neg; r.sub = sub; r.cen = cen;
      r.fwe = fwe; r.we1 = we1; r.ldr = ldr; r.str = str; r.s2 = s2; r.fwd = 3'b000;
      return r;
   endfunction

   // Reference model: bit-by-bit shifting/rotation and value-range opcode decoding.
   function automatic res_t model(pkt_t p, logic [2:0] fwd);
      res_t r;
      logic [31:0] src, sr, sl, ro;
      logic [2:0]  low;
      logic        mov, lsu, alu;
      int          sh_r, sh_l, idx;
      case (p.fsel)
         2'd0:    src = p.d2;
         2'd1:    src = fwd_v[0];
         2'd2:    src = fwd_v[1];
         default: src = 32'h0;
      endcase
      sh_r = int'(p.shr);
      sh_l = int'(p.shl);
      for (int j = 0; j < 32; j++) begin
         ro[j] = src[(j + sh_r) % 32];
         idx = j + sh_r;
         if (idx < 32) sr[j] = src[idx];
         else          sr[j] = p.sext & src[31];
         if (j >= sh_l) sl[j] = src[j - sh_l];
         else           sl[j] = 1'b0;
      end
      mov = (p.opc < 5'd4);
      lsu = (p.opc == 5'd8) || (p.opc == 5'd9);
      alu = (p.opc >= 5'd16);
      low = p.opc[2:0];
      r.d1  = mov ? 32'h0 : p.rp;
      r.d2  = p.ror ? ro : ((p.maskr ? sr : 32'h0) | (p.maskl ? sl : 32'h0));
      r.rd  = p.rd;
      if (mov || lsu)     r.opr = 2'd0;
      else if (low < 3'd4) r.opr = 2'd0;
      else if (low < 3'd6) r.opr = 2'd1;
      else if (low == 3'd6) r.opr = 2'd2;
      else                 r.opr = 2'd3;
      r.sub = alu && (low == 3'd2 || low == 3'd3);
      r.cen = alu && (low == 3'd1 || low == 3'd3);
      r.neg = r.sub || (alu && low == 3'd5);
      r.fwe = alu;
      r.we1 = !lsu;
      r.ldr = (p.opc == 5'd8);
      r.str = (p.opc == 5'd9);
      r.s2  = !lsu && p.shl == 5'd0 && p.shr == 5'd0 && !p.ror;
      r.fwd = fwd;
      return r;
   endfunction

   task automatic drive(input pkt_t p);
      bus.in_opc   = p.opc;   bus.in_rd    = p.rd;    bus.in_rm   = p.rm;
      bus.rp_data  = p.rp;    bus.in_d2    = p.d2;    bus.in_fsel = p.fsel;
      bus.in_shl   = p.shl;   bus.in_shr   = p.shr;
      bus.in_maskl = p.maskl; bus.in_maskr = p.maskr;
      bus.in_sext  = p.sext;  bus.in_ror   = p.ror;
      bus.fwd_data = {fwd_v[1], fwd_v[0]};
   endtask

   task automatic check_out(input string tag, input res_t e);
      chk({tag, ".d1"},  bus.out_d1,      e.d1);
      chk({tag, ".d2"},  bus.out_d2,      e.d2);
      chk({tag, ".rd"},  bus.out_rd,      e.rd);
      chk({tag, ".opr"}, bus.out_opr,     e.opr);
      chk({tag, ".neg"}, bus.out_neg,     e.neg);
      chk({tag, ".sub"}, bus.out_sub,     e.sub);
      chk({tag, ".cen"}, bus.out_cen,     e.cen);
      chk({tag, ".fwe"}, bus.out_fwe,     e.fwe);
      chk({tag, ".we1"}, bus.out_we1,     e.we1);
      chk({tag, ".ldr"}, bus.out_isldr,   e.ldr);
      chk({tag, ".str"}, bus.out_isstr,   e.str);
      chk({tag, ".s2"},  bus.out_s2fwdok, e.s2);
      chk({tag, ".fwd"}, bus.out_fwd,     e.fwd);
   endtask

   task automatic idle();
      pkt_t z;
      z = mkp(5'd0, 4'd0, 32'h0, 32'h0, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(z);
      bus.in_vld = 1'b0; bus.out_rdy = 1'b1; bus.flush_i = 1'b0; bus.cnt_clr = 1'b0;
      bus.haz_vld = 3'b000; bus.haz_rd = 12'h000; bus.haz_fwdok = 3'b000;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      pkt_t pa, px, py, pz, pw, pv, pr;
      res_t ex, er;
      logic       ev, rdy, hazard;
      logic [2:0] hv, fok, fwd;
      logic [3:0] hrd [3];
      logic [15:0] cnt;

      fwd_v[0] = 32'hAAAA_0001;
      fwd_v[1] = 32'h5555_0002;

      // Directed vector table: {opc,rm,rp,d2,fsel,shl,shr,maskl,maskr,sext,ror} -> expected outputs
      tv[0]  = '{mkp(5'b10000, 4'd3, 32'h5, 32'h7, 2'd0, 5'd0, 5'd0, 1, 0, 0, 0),
                 mke(32'h5, 32'h7, 2'd0, 0, 0, 0, 1, 1, 0, 0, 1)};
      tv[1]  = '{mkp(5'b00000, 4'd1, 32'hFFFF_FFFF, 32'h8000_0000, 2'd0, 5'd0, 5'd4, 0, 1, 1, 0),
                 mke(32'h0, 32'hF800_0000, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0)};
      tv[2]  = '{mkp(5'b00000, 4'd1, 32'hFFFF_FFFF, 32'h8000_0000, 2'd0, 5'd0, 5'd4, 0, 1, 0, 0),
                 mke(32'h0, 32'h0800_0000, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0)};
      tv[3]  = '{mkp(5'b00000, 4'd1, 32'hFFFF_FFFF, 32'h0000_000F, 2'd0, 5'd0, 5'd4, 0, 0, 0, 1),
                 mke(32'h0, 32'hF000_0000, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0)};
      tv[4]  = '{mkp(5'b11101, 4'd2, 32'h12, 32'h34, 2'd0, 5'd0, 5'd0, 1, 0, 0, 0),
                 mke(32'h12, 32'h34, 2'd1, 1, 0, 0, 1, 1, 0, 0, 1)};
      tv[5]  = '{mkp(5'b01001, 4'd4, 32'hDEAD_0000, 32'h10, 2'd0, 5'd0, 5'd0, 1, 0, 0, 0),
                 mke(32'hDEAD_0000, 32'h10, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0)};
      tv[6]  = '{mkp(5'b01000, 4'd4, 32'hBEEF_0000, 32'h20, 2'd0, 5'd0, 5'd0, 1, 0, 0, 0),
                 mke(32'hBEEF_0000, 32'h20, 2'd0, 0, 0, 0, 0, 0, 1, 0, 0)};
      tv[7]  = '{mkp(5'b10010, 4'd5, 32'h100, 32'h3, 2'd0, 5'd0, 5'd0, 1, 0, 0, 0),
                 mke(32'h100, 32'h3, 2'd0, 1, 1, 0, 1, 1, 0, 0, 1)};
      tv[8]  = '{mkp(5'b10011, 4'd6, 32'h200, 32'h4, 2'd0, 5'd0, 5'd0, 1, 0, 0, 0),
                 mke(32'h200, 32'h4, 2'd0, 1, 1, 1, 1, 1, 0, 0, 1)};
      tv[9]  = '{mkp(5'b10110, 4'd7, 32'h300, 32'h5, 2'd0, 5'd0, 5'd0, 1, 0, 0, 0),
                 mke(32'h300, 32'h5, 2'd2, 0, 0, 0, 1, 1, 0, 0, 1)};
      tv[10] = '{mkp(5'b10111, 4'd8, 32'h400, 32'h6, 2'd0, 5'd0, 5'd0, 1, 0, 0, 0),
                 mke(32'h400, 32'h6, 2'd3, 0, 0, 0, 1, 1, 0, 0, 1)};
      tv[11] = '{mkp(5'b10000, 4'd9, 32'h500, 32'h99, 2'd2, 5'd8, 5'd0, 1, 0, 0, 0),
                 mke(32'h500, 32'h5500_0200, 2'd0, 0, 0, 0, 1, 1, 0, 0, 0)};
      tv[12] = '{mkp(5'b10000, 4'd10, 32'h600, 32'h99, 2'd3, 5'd0, 5'd0, 1, 0, 0, 0),
                 mke(32'h600, 32'h0, 2'd0, 0, 0, 0, 1, 1, 0, 0, 1)};
      tv[13] = '{mkp(5'b10100, 4'd11, 32'h700, 32'h99, 2'd1, 5'd4, 5'd4, 1, 1, 0, 0),
                 mke(32'h700, 32'hAAAA_A010, 2'd1, 0, 0, 0, 1, 1, 0, 0, 0)};
      tv[14] = '{mkp(5'b00011, 4'd12, 32'h800, 32'h8000_0000, 2'd0, 5'd0, 5'd31, 0, 1, 1, 0),
                 mke(32'h0, 32'hFFFF_FFFF, 2'd0, 0, 0, 0, 0, 1, 0, 0, 0)};
      tv[15] = '{mkp(5'b10001, 4'd13, 32'h900, 32'h1234_5678, 2'd0, 5'd0, 5'd0, 0, 0, 0, 1),
                 mke(32'h900, 32'h1234_5678, 2'd0, 0, 0, 1, 1, 1, 0, 0, 0)};

      idle();
      bus_s.flush_i = 1'b0; bus_s.in_vld = 1'b0; bus_s.in_opc = 5'd0; bus_s.in_rd = 4'd0;
      bus_s.in_rm = 4'd5; bus_s.in_d2 = 32'h0; bus_s.in_fsel = 2'd0; bus_s.in_shl = 5'd0;
      bus_s.in_shr = 5'd0; bus_s.in_maskl = 1'b0; bus_s.in_maskr = 1'b0; bus_s.in_sext = 1'b0;
      bus_s.in_ror = 1'b0; bus_s.rp_data = 32'h0; bus_s.fwd_data = 64'h0; bus_s.haz_vld = 3'b000;
      bus_s.haz_rd = 12'h005; bus_s.haz_fwdok = 3'b000; bus_s.out_rdy = 1'b1; bus_s.cnt_clr = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      chk("rst.out_vld", bus.out_vld, 1'b0);
      chk("rst.stall_cnt", bus.stall_cnt, 16'h0);
      chk("rst.out_d1", bus.out_d1, 32'h0);
      chk("rst.out_d2", bus.out_d2, 32'h0);
      nrst = 1'b1;
      tick();

      // Table vectors, back to back at one per cycle
      for (int i = 0; i < 16; i++) begin
         tv[i].p.rd = 4'(i);
         tv[i].e.rd = 4'(i);
         drive(tv[i].p);
         bus.in_vld = 1'b1;
         #1;
         chk($sformatf("vec%0d.in_rdy", i), bus.in_rdy, 1'b1);
         chk($sformatf("vec%0d.rp_addr", i), bus.rp_addr, tv[i].p.rm);
         tick();
         chk($sformatf("vec%0d.out_vld", i), bus.out_vld, 1'b1);
         check_out($sformatf("vec%0d", i), tv[i].e);
         $display("vec %0d opc=%b d1=%h d2=%h opr=%0d", i, tv[i].p.opc, bus.out_d1, bus.out_d2, bus.out_opr);
      end

      // Non-forwardable hazard stalls, then becomes forwardable
      pa = mkp(5'b10000, 4'd3, 32'h33, 32'h44, 2'd0, 5'd0, 5'd0, 1, 0, 0, 0);
      pa.rd = 4'd14;
      drive(pa);
      bus.in_vld = 1'b1;
      tick();
      bus.haz_vld = 3'b001; bus.haz_rd = 12'h003; bus.haz_fwdok = 3'b000;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("haz.stall%0d.in_rdy", k), bus.in_rdy, 1'b0);
         tick();
         if (k == 0) chk("haz.drain.out_vld", bus.out_vld, 1'b0);
      end
      chk("haz.stall_cnt", bus.stall_cnt, 16'd3);
      bus.haz_fwdok = 3'b001;
      #1;
      chk("haz.fwdok.in_rdy", bus.in_rdy, 1'b1);
      tick();
      chk("haz.fwdok.out_vld", bus.out_vld, 1'b1);
      check_out("haz.fwdok", model(pa, 3'b001));
      $display("haz fwd=%b stall_cnt=%0d", bus.out_fwd, bus.stall_cnt);
      bus.haz_vld = 3'b110; bus.haz_rd = 12'h330; bus.haz_fwdok = 3'b110;
      tick();
      chk("haz.lowest.fwd", bus.out_fwd, 3'b010);
      bus.haz_fwdok = 3'b010;
      #1;
      chk("haz.mixed.in_rdy", bus.in_rdy, 1'b0);
      tick();
      chk("haz.mixed.stall_cnt", bus.stall_cnt, 16'd4);
      bus.haz_vld = 3'b111; bus.haz_rd = 12'h456; bus.haz_fwdok = 3'b000;
      #1;
      chk("haz.nomatch.in_rdy", bus.in_rdy, 1'b1);
      tick();
      chk("haz.nomatch.fwd", bus.out_fwd, 3'b000);
      bus.haz_rd = 12'h003; bus.cnt_clr = 1'b1;
      tick();
      chk("haz.clr_wins.stall_cnt", bus.stall_cnt, 16'd0);
      bus.cnt_clr = 1'b0;
      idle();
      tick();

      // Backpressure: hold, then resume at full throughput
      px = mkp(5'b10110, 4'd1, 32'h1111, 32'h2222, 2'd0, 5'd0, 5'd0, 1, 0, 0, 0); px.rd = 4'd1;
      py = mkp(5'b10001, 4'd2, 32'h3333, 32'h4444, 2'd0, 5'd1, 5'd0, 1, 0, 0, 0); py.rd = 4'd2;
      pz = mkp(5'b01000, 4'd3, 32'h5555, 32'h6666, 2'd1, 5'd0, 5'd0, 1, 0, 0, 0); pz.rd = 4'd3;
      drive(px); bus.in_vld = 1'b1; bus.out_rdy = 1'b1;
      tick();
      ex = model(px, 3'b000);
      drive(py); bus.out_rdy = 1'b0;
      #1;
      chk("bp.hold.in_rdy", bus.in_rdy, 1'b0);
      tick();
      tick();
      chk("bp.hold.out_vld", bus.out_vld, 1'b1);
      check_out("bp.hold", ex);
      bus.out_rdy = 1'b1;
      #1;
      chk("bp.resume.in_rdy", bus.in_rdy, 1'b1);
      tick();
      check_out("bp.y", model(py, 3'b000));
      drive(pz);
      tick();
      chk("bp.z.out_vld", bus.out_vld, 1'b1);
      check_out("bp.z", model(pz, 3'b000));
      $display("backpressure d1=%h d2=%h", bus.out_d1, bus.out_d2);

      // Flush with a held packet and a pending input
      pw = mkp(5'b10000, 4'd4, 32'h7777, 32'h8888, 2'd0, 5'd0, 5'd0, 1, 0, 0, 0);
      bus.out_rdy = 1'b0;
      drive(pw); bus.flush_i = 1'b1;
      #1;
      chk("flush.in_rdy", bus.in_rdy, 1'b0);
      tick();
      chk("flush.out_vld", bus.out_vld, 1'b0);
      bus.flush_i = 1'b0; bus.in_vld = 1'b0;
      tick();
      chk("flush.noload.out_vld", bus.out_vld, 1'b0);
      $display("flush out_vld=%b", bus.out_vld);

      // Async reset while a packet is held
      pv = mkp(5'b10000, 4'd7, 32'h77, 32'h88, 2'd0, 5'd0, 5'd0, 1, 0, 0, 0); pv.rd = 4'd9;
      drive(pv); bus.in_vld = 1'b1; bus.out_rdy = 1'b1;
      tick();
      bus.out_rdy = 1'b0; bus.haz_vld = 3'b001; bus.haz_rd = 12'h007; bus.haz_fwdok = 3'b000;
      tick();
      chk("rsthold.stall_cnt", bus.stall_cnt, 16'd1);
      chk("rsthold.out_d1", bus.out_d1, 32'h77);
      nrst = 1'b0;
      #1;
      chk("rsthold.out_vld", bus.out_vld, 1'b0);
      chk("rsthold.d1_zero", bus.out_d1, 32'h0);
      chk("rsthold.d2_zero", bus.out_d2, 32'h0);
      chk("rsthold.rd_zero", bus.out_rd, 4'h0);
      chk("rsthold.cnt_zero", bus.stall_cnt, 16'h0);
      idle();
      tick();
      nrst = 1'b1;
      $display("reset mid-hold out_vld=%b", bus.out_vld);

      // Stall counter saturation on the CNTW=2 instance
      bus_s.in_vld = 1'b1; bus_s.haz_vld = 3'b001;
      tick();
      tick();
      chk("sat.cnt2", bus_s.stall_cnt, 2'd2);
      tick();
      tick();
      tick();
      chk("sat.cnt5", bus_s.stall_cnt, 2'd3);
      bus_s.cnt_clr = 1'b1;
      tick();
      chk("sat.clr", bus_s.stall_cnt, 2'd0);
      bus_s.cnt_clr = 1'b0; bus_s.in_vld = 1'b0;
      $display("saturation stall_cnt=%0d", bus_s.stall_cnt);

      // Randomized traffic against the reference model
      ev  = 1'b0;
      cnt = 16'h0;
      er  = mke(32'h0, 32'h0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 400; n++) begin
         pr.opc = 5'($urandom); pr.rd = 4'($urandom); pr.rm = 4'($urandom_range(0, 3));
         pr.rp = $urandom; pr.d2 = $urandom; pr.fsel = 2'($urandom);
         pr.shl = 5'($urandom); pr.shr = 5'($urandom);
         pr.maskl = 1'($urandom); pr.maskr = 1'($urandom);
         pr.sext = 1'($urandom); pr.ror = 1'($urandom_range(0, 3) == 0);
         fwd_v[0] = $urandom; fwd_v[1] = $urandom;
         hv  = 3'($urandom); fok = 3'($urandom);
         for (int i = 0; i < 3; i++) hrd[i] = 4'($urandom_range(0, 3));
         drive(pr);
         bus.in_vld  = ($urandom_range(0, 3) != 0);
         bus.out_rdy = ($urandom_range(0, 3) != 0);
         bus.flush_i = ($urandom_range(0, 15) == 0);
         bus.cnt_clr = ($urandom_range(0, 31) == 0);
         bus.haz_vld = hv; bus.haz_fwdok = fok; bus.haz_rd = {hrd[2], hrd[1], hrd[0]};
         hazard = 1'b0;
         fwd    = 3'b000;
         for (int i = 0; i < 3; i++) begin
            if (hv[i] && hrd[i] == pr.rm) begin
               if (!fok[i]) hazard = 1'b1;
               else if (fwd == 3'b000) fwd = 3'(1 << i);
            end
         end
         rdy = (!ev || bus.out_rdy) && !hazard && !bus.flush_i;
         #1;
         chk($sformatf("rnd%0d.in_rdy", n), bus.in_rdy, rdy);
         if (bus.cnt_clr) cnt = 16'h0;
         else if (bus.in_vld && hazard && !bus.flush_i && cnt != 16'hFFFF) cnt = cnt + 16'd1;
         if (bus.flush_i) ev = 1'b0;
         else if (bus.in_vld && rdy) begin
            ev = 1'b1;
            er = model(pr, fwd);
            $display("rnd %0d load opc=%b d2=%h fwd=%b", n, pr.opc, er.d2, fwd);
         end else if (bus.out_rdy) ev = 1'b0;
         tick();
         chk($sformatf("rnd%0d.out_vld", n), bus.out_vld, ev);
         if (ev) check_out($sformatf("rnd%0d", n), er);
         chk($sformatf("rnd%0d.stall_cnt", n), bus.stall_cnt, cnt);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
